// File: rtl/fb_axi_pkg.sv
// fb_axi_pkg: shared AXI constants, scan FSM states and beat-size helper for the framebuffer fetch path
package fb_axi_pkg;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_LOCK_NORMAL = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN
    } scan_state_t;

    function automatic logic [2:0] beat_size(input int unsigned bytes);
        beat_size = 3'd0;
        for (int i = 0; i < 8; i++)
            if (bytes == (32'd1 << i)) beat_size = 3'(i);
    endfunction
endpackage

// File: rtl/fb_credit_counter.sv
// fb_credit_counter: saturating outstanding-burst counter; simultaneous inc/dec cancel, dec at zero is ignored
module fb_credit_counter #(
    parameter int unsigned MAX = 4,
    localparam int W = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         i_inc,
    input  logic         i_dec,
    output logic [W-1:0] o_count,
    output logic [W-1:0] o_count_next
);
    localparam logic [W-1:0] LIMIT = W'(MAX);
    localparam logic [W-1:0] ONE   = W'(1);

    logic [W-1:0] r_count;
    logic         w_inc;
    logic         w_dec;

    assign w_dec   = i_dec & (r_count != '0);
    assign w_inc   = i_inc & ((r_count != LIMIT) | w_dec);
    assign o_count = r_count;

    // Next count: a matched inc/dec pair leaves the count alone
    always_comb
        o_count_next = (w_inc & ~w_dec) ? r_count + ONE :
                       (w_dec & ~w_inc) ? r_count - ONE : r_count;

    // Credit register
    always_ff @(posedge clk)
        r_count <= !resetn ? '0 : o_count_next;
endmodule

// File: rtl/fb_scan_read_requester.sv
// fb_scan_read_requester: issues the AR burst stream that fetches one framebuffer frame, credit-limited
module fb_scan_read_requester
    import fb_axi_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE       = 32'h0000_0000,
    parameter int unsigned LINE_STRIDE     = 4096,
    parameter int unsigned LINE_BURSTS     = 8,
    parameter int unsigned V_LINES         = 720,
    parameter int unsigned BURST_LEN       = 16,
    parameter int unsigned BEAT_BYTES      = 16,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter logic [7:0]  ARID            = 8'h01
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        frame_start,
    input  logic        r_last_done,
    output logic        busy,
    output logic        frame_done,
    output logic        frame_overrun,
    output logic [7:0]  axi_arid,
    output logic [31:0] axi_araddr,
    output logic [7:0]  axi_arlen,
    output logic [2:0]  axi_arsize,
    output logic [1:0]  axi_arburst,
    output logic [1:0]  axi_arlock,
    output logic        axi_arvalid,
    input  logic        axi_arready
);
    localparam int          BW          = (LINE_BURSTS > 1) ? $clog2(LINE_BURSTS) : 1;
    localparam int          LW          = (V_LINES > 1) ? $clog2(V_LINES) : 1;
    localparam int          CW          = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned LINE_BYTES  = LINE_BURSTS * BURST_LEN * BEAT_BYTES;
    localparam int unsigned BASE_U      = ADDR_BASE;
    localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN * BEAT_BYTES);
    localparam logic [31:0] STRIDE      = 32'(LINE_STRIDE);
    localparam logic [BW-1:0] LAST_BURST = BW'(LINE_BURSTS - 1);
    localparam logic [LW-1:0] LAST_LINE  = LW'(V_LINES - 1);
    localparam logic [BW-1:0] B_ONE      = BW'(1);
    localparam logic [LW-1:0] L_ONE      = LW'(1);
    localparam logic [CW-1:0] CREDITS    = CW'(MAX_OUTSTANDING);

    if (LINE_BYTES > LINE_STRIDE) begin : g_bad_stride
        $error("fb_scan_read_requester: a line of bursts does not fit in LINE_STRIDE");
    end
    if (!(((4096 % LINE_STRIDE) == 0 && (BASE_U % LINE_STRIDE) + LINE_BYTES <= LINE_STRIDE) ||
          ((LINE_STRIDE % 4096) == 0 && (BASE_U % 4096) + LINE_BYTES <= 4096))) begin : g_bad_4k
        $error("fb_scan_read_requester: burst addresses could cross a 4 KB boundary");
    end

    scan_state_t   r_state, w_state;
    logic [31:0]   r_line_addr, w_line_addr;
    logic [31:0]   r_araddr, w_araddr;
    logic [BW-1:0] r_burst, w_burst;
    logic [LW-1:0] r_line, w_line;
    logic          r_arvalid, w_arvalid;
    logic          r_done, w_done;
    logic          r_overrun, w_overrun;
    logic          w_hs;
    logic [CW-1:0] w_count, w_count_next;

    assign w_hs = r_arvalid & axi_arready;

    fb_credit_counter #(.MAX(MAX_OUTSTANDING)) u_credit (
        .clk          (clk),
        .resetn       (resetn),
        .i_inc        (w_hs),
        .i_dec        (r_last_done),
        .o_count      (w_count),
        .o_count_next (w_count_next)
    );

    // Next-state: walk bursts within a line, lines within the frame, then wait for all credits back
    always_comb begin
        w_state     = r_state;
        w_line_addr = r_line_addr;
        w_araddr    = r_araddr;
        w_burst     = r_burst;
        w_line      = r_line;
        w_done      = 1'b0;
        w_overrun   = frame_start & (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: if (frame_start) begin
                w_state     = ST_ISSUE;
                w_line_addr = ADDR_BASE;
                w_araddr    = ADDR_BASE;
                w_burst     = '0;
                w_line      = '0;
            end
            ST_ISSUE: if (w_hs) begin
                if (r_burst != LAST_BURST) begin
                    w_burst  = r_burst + B_ONE;
                    w_araddr = r_araddr + BURST_BYTES;
                end else if (r_line != LAST_LINE) begin
                    w_burst     = '0;
                    w_line      = r_line + L_ONE;
                    w_line_addr = r_line_addr + STRIDE;
                    w_araddr    = r_line_addr + STRIDE;
                end else begin
                    w_state = ST_DRAIN;
                end
            end
            ST_DRAIN: if (w_count == '0) begin
                w_state = ST_IDLE;
                w_done  = 1'b1;
            end
            default: w_state = ST_IDLE;
        endcase
        // A pending request is held regardless of credits; a new one needs a free credit
        w_arvalid = (r_state == ST_IDLE) ? frame_start :
                    (w_state == ST_ISSUE) & ((r_arvalid & ~w_hs) | (w_count_next < CREDITS));
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_line_addr <= ADDR_BASE;
            r_araddr    <= ADDR_BASE;
            r_burst     <= '0;
            r_line      <= '0;
            r_arvalid   <= 1'b0;
            r_done      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_line_addr <= w_line_addr;
            r_araddr    <= w_araddr;
            r_burst     <= w_burst;
            r_line      <= w_line;
            r_arvalid   <= w_arvalid;
            r_done      <= w_done;
            r_overrun   <= w_overrun;
        end
    end

    assign busy          = (r_state != ST_IDLE);
    assign frame_done    = r_done;
    assign frame_overrun = r_overrun;
    assign axi_arvalid   = r_arvalid;
    assign axi_araddr    = r_araddr;
    assign axi_arid      = ARID;
    assign axi_arlen     = 8'(BURST_LEN - 1);
    assign axi_arsize    = beat_size(BEAT_BYTES);
    assign axi_arburst   = AXI_BURST_INCR;
    assign axi_arlock    = AXI_LOCK_NORMAL;
endmodule
